// File: rtl/video_pattern_gen.sv
// Programmable video timing generator (HS/VS/DE) with frame-synchronous test patterns.
// Optional bouncing 32x32 box overlay when MOVING_BOX_EN is defined.
module video_pattern_gen #(
  parameter int H_SYNC  = 44,
  parameter int H_BACK  = 148,
  parameter int H_DISP  = 1920,
  parameter int H_FRONT = 88,
  parameter int V_SYNC  = 5,
  parameter int V_BACK  = 36,
  parameter int V_DISP  = 1080,
  parameter int V_FRONT = 4,
  parameter int HS_POL  = 1,
  parameter int VS_POL  = 1,
  parameter int COORD_W = 12
) (
  input  logic               pixel_clk,
  input  logic               sys_rst_n,
  input  logic [2:0]         pattern_sel,
  input  logic [23:0]        solid_rgb,
  output logic               video_hs,
  output logic               video_vs,
  output logic               video_de,
  output logic [23:0]        video_rgb,
  output logic [COORD_W-1:0] pixel_xpos,
  output logic [COORD_W-1:0] pixel_ypos,
  output logic               frame_start
);

  localparam logic [COORD_W-1:0] HSyncEnd  = COORD_W'(H_SYNC);
  localparam logic [COORD_W-1:0] HActStart = COORD_W'(H_SYNC + H_BACK);
  localparam logic [COORD_W-1:0] HActEnd   = COORD_W'(H_SYNC + H_BACK + H_DISP);
  localparam logic [COORD_W-1:0] HTotLast  = COORD_W'(H_SYNC + H_BACK + H_DISP + H_FRONT - 1);
  localparam logic [COORD_W-1:0] HDispLast = COORD_W'(H_DISP - 1);
  localparam logic [COORD_W-1:0] VSyncEnd  = COORD_W'(V_SYNC);
  localparam logic [COORD_W-1:0] VActStart = COORD_W'(V_SYNC + V_BACK);
  localparam logic [COORD_W-1:0] VActEnd   = COORD_W'(V_SYNC + V_BACK + V_DISP);
  localparam logic [COORD_W-1:0] VTotLast  = COORD_W'(V_SYNC + V_BACK + V_DISP + V_FRONT - 1);
  localparam logic [COORD_W-1:0] VDispLast = COORD_W'(V_DISP - 1);
  localparam logic [COORD_W-1:0] BarW      = COORD_W'(H_DISP / 8);
  localparam logic               HsOn      = (HS_POL != 0);
  localparam logic               VsOn      = (VS_POL != 0);

  logic [COORD_W-1:0] h_cnt, v_cnt, bnd_q, x, y;
  logic [2:0]         pat_q, bar_q;
  logic [23:0]        solid_q, pat_rgb;
  logic               raw_hs, raw_vs, h_act, v_act, de, frame_first;

`ifdef MOVING_BOX_EN
  localparam logic [COORD_W-1:0] BoxXMax = COORD_W'((H_DISP > 32) ? H_DISP - 32 : 0);
  localparam logic [COORD_W-1:0] BoxYMax = COORD_W'((V_DISP > 32) ? V_DISP - 32 : 0);
  localparam logic [COORD_W-1:0] BoxSize = COORD_W'(32);

  logic [COORD_W-1:0] bx, by;
  logic               bx_neg, by_neg, in_box;

  // Returns {new_direction_negative, new_position}; reverses instead of leaving [0, lim].
  function automatic logic [COORD_W:0] box_step(input logic [COORD_W-1:0] pos, input logic neg,
                                               input logic [COORD_W-1:0] lim);
    logic [COORD_W-1:0] two;
    two = COORD_W'(2);
    if (!neg) begin
      if (pos + two > lim) return {1'b1, (pos >= two) ? pos - two : pos};
      return {1'b0, pos + two};
    end
    if (pos < two) return {1'b0, (pos + two <= lim) ? pos + two : pos};
    return {1'b1, pos - two};
  endfunction

  always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      bx     <= '0;
      by     <= '0;
      bx_neg <= 1'b0;
      by_neg <= 1'b0;
    end else if (frame_first) begin
      {bx_neg, bx} <= box_step(bx, bx_neg, BoxXMax);
      {by_neg, by} <= box_step(by, by_neg, BoxYMax);
    end
  end
`endif

  always_comb begin
    raw_hs      = h_cnt < HSyncEnd;
    raw_vs      = v_cnt < VSyncEnd;
    h_act       = (h_cnt >= HActStart) && (h_cnt < HActEnd);
    v_act       = (v_cnt >= VActStart) && (v_cnt < VActEnd);
    de          = h_act && v_act;
    x           = h_cnt - HActStart;
    y           = v_cnt - VActStart;
    frame_first = (h_cnt == '0) && (v_cnt == '0);
    pat_rgb     = 24'h000000;
    case (pat_q)
      3'd0: begin
        case (bar_q)
          3'd0:    pat_rgb = 24'hFFFFFF;
          3'd1:    pat_rgb = 24'hFFFF00;
          3'd2:    pat_rgb = 24'h00FFFF;
          3'd3:    pat_rgb = 24'h00FF00;
          3'd4:    pat_rgb = 24'hFF00FF;
          3'd5:    pat_rgb = 24'hFF0000;
          3'd6:    pat_rgb = 24'h0000FF;
          default: pat_rgb = 24'h000000;
        endcase
      end
      3'd1: pat_rgb = {3{x[7:0]}};
      3'd2: begin
        if ((x[4:0] == 5'd0) || (y[4:0] == 5'd0) || (x == HDispLast) || (y == VDispLast)) begin
          pat_rgb = 24'hFFFFFF;
        end
      end
      3'd3: pat_rgb = (x[5] ^ y[5]) ? 24'hFFFFFF : 24'h000000;
      3'd4: pat_rgb = solid_q;
      default: pat_rgb = 24'h000000;
    endcase
`ifdef MOVING_BOX_EN
    in_box = (x >= bx) && ((x - bx) < BoxSize) && (y >= by) && ((y - by) < BoxSize);
    if (in_box) pat_rgb = 24'hFF8000;
`endif
  end

  always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      h_cnt       <= '0;
      v_cnt       <= '0;
      pat_q       <= 3'd0;
      solid_q     <= 24'h000000;
      bar_q       <= 3'd0;
      bnd_q       <= '0;
      video_hs    <= !HsOn;
      video_vs    <= !VsOn;
      video_de    <= 1'b0;
      video_rgb   <= 24'h000000;
      pixel_xpos  <= '0;
      pixel_ypos  <= '0;
      frame_start <= 1'b0;
    end else begin
      if (h_cnt == HTotLast) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == VTotLast) ? '0 : v_cnt + 1'b1;
      end else begin
        h_cnt <= h_cnt + 1'b1;
      end
      if (frame_first) begin
        pat_q   <= pattern_sel;
        solid_q <= solid_rgb;
      end
      // bnd_q holds the last x of the current bar; bar 7 absorbs any remainder.
      if (!h_act) begin
        bar_q <= 3'd0;
        bnd_q <= BarW - 1'b1;
      end else if ((x == bnd_q) && (bar_q != 3'd7)) begin
        bar_q <= bar_q + 3'd1;
        bnd_q <= bnd_q + BarW;
      end
      video_hs    <= raw_hs ? HsOn : !HsOn;
      video_vs    <= raw_vs ? VsOn : !VsOn;
      video_de    <= de;
      video_rgb   <= de ? pat_rgb : 24'h000000;
      pixel_xpos  <= de ? x : '0;
      pixel_ypos  <= de ? y : '0;
      frame_start <= frame_first;
    end
  end

endmodule

// File: doc/video_pattern_gen.md
Name: video_pattern_gen

Overview:
- Parametrised successor to the fixed-timing video driver and colour-bar display pair.
- Single block that generates programmable-resolution video timing (HS/VS/DE) plus a runtime-selectable test pattern.
- Sits between the pixel PLL output and the DVI/TMDS transmitter; output bus is 24-bit RGB aligned with sync and DE.
- Pattern and solid colour change only on frame boundaries, so there is no tearing.

Parameters:
- H_SYNC, 44, horizontal sync width in pixels
- H_BACK, 148, horizontal back porch
- H_DISP, 1920, active pixels per line (must be ≥ 8)
- H_FRONT, 88, horizontal front porch
- V_SYNC, 5, vertical sync width in lines
- V_BACK, 36, vertical back porch
- V_DISP, 1080, active lines
- V_FRONT, 4, vertical front porch
- HS_POL, 1, HS active level
- VS_POL, 1, VS active level
- COORD_W, 12, width of counters and coordinate outputs

Ports:
- pixel_clk  input  1  pixel clock
- sys_rst_n  input  1  reset
- pattern_sel  input  3  pattern request, sampled at frame start
- solid_rgb  input  24  colour for solid pattern, sampled at frame start
- video_hs  output  1  horizontal sync
- video_vs  output  1  vertical sync
- video_de  output  1  data enable
- video_rgb  output  24  pixel data {R,G,B}
- pixel_xpos  output  COORD_W  active x of the current video_rgb pixel, 0 when DE low
- pixel_ypos  output  COORD_W  active y of the current video_rgb pixel, 0 when DE low
- frame_start  output  1  one-cycle pulse, first cycle of each frame

Interface decision:
- One clock; reset is asynchronous and active-low.
- Clock is pixel_clk; reset is sys_rst_n.

Behaviour:
- Totals: H_TOTAL = H_SYNC+H_BACK+H_DISP+H_FRONT; V_TOTAL likewise.
- h_cnt counts 0..H_TOTAL-1 and wraps to 0.
- v_cnt increments when h_cnt wraps; v_cnt wraps to 0 after V_TOTAL-1.
- Segment order in each line/frame: sync, back porch, active, front porch.
- Raw HS: active when h_cnt < H_SYNC.
- Raw VS: active when v_cnt < V_SYNC.
- Raw DE: h_cnt in [H_SYNC+H_BACK, H_SYNC+H_BACK+H_DISP) AND v_cnt in the equivalent vertical window.
- Active coordinates: x = h_cnt-(H_SYNC+H_BACK), y = v_cnt-(V_SYNC+V_BACK).
- Frame start: h_cnt==0 && v_cnt==0.
  - Latch pattern_sel into pat_q and solid_rgb into solid_q.
  - Both are held stable for the whole frame.
- Patterns, evaluated on pat_q:
  - 0 colour bar: 8 bars of width BW = H_DISP/8, in order white FFFFFF, yellow FFFF00, cyan 00FFFF, green 00FF00, magenta FF00FF, red FF0000, blue 0000FF, black 000000. Bar index = min(x/BW, 7), so the last bar absorbs the remainder. Implement with a per-line bar counter and boundary register, no divider.
  - 1 gray ramp: R=G=B=x[7:0], wraps every 256 pixels.
  - 2 grid: FFFFFF when x[4:0]==0, y[4:0]==0, x==H_DISP-1 or y==V_DISP-1; else 000000.
  - 3 checkerboard: FFFFFF when x[5]^y[5]; else 000000.
  - 4 solid: solid_q.
  - 5-7: 000000.
- Latency:
  - All outputs are registered.
  - video_hs, video_vs, video_de, video_rgb, pixel_xpos, pixel_ypos and frame_start are mutually aligned and lag the counters by exactly 1 cycle.
  - When DE is low, video_rgb = 0, pixel_xpos = 0 and pixel_ypos = 0.
- Polarity: video_hs = raw_hs ? HS_POL : ~HS_POL; video_vs likewise with VS_POL.
- Reset values:
  - Counters 0; pat_q 0; solid_q 0.
  - video_de 0; video_rgb 0; pixel_xpos 0; pixel_ypos 0; frame_start 0.
  - video_hs = ~HS_POL; video_vs = ~VS_POL.
- After reset release:
  - The first clock evaluates h_cnt=v_cnt=0.
  - frame_start pulses on the second clock edge after deassertion.
- Reset mid-frame aborts the frame immediately; timing restarts from (0,0) with no partial-line glitch beyond the reset values.
- pattern_sel changes mid-frame have no effect until the next frame_start.

Optional Feature:
- Macro: MOVING_BOX_EN.
- Defined:
  - A 32x32 box colour FF8000 is overlaid on every pattern, including 5-7.
  - Box position registers bx, by reset to 0.
  - Position updates once per frame at frame start by ±2 pixels on each axis.
  - Direction reverses on the axis when the next position would exceed H_DISP-32 / V_DISP-32 or go below 0, so the box bounces.
  - Overlay is applied in the same pipeline stage; latency is unchanged.
- Undefined: no box logic and no overlay; outputs depend only on the pattern.

Test Plan:
Small timing for all scenarios: H 4/4/16/4 (H_TOTAL=28), V 2/2/8/2 (V_TOTAL=14), HS_POL=VS_POL=1.
- Timing: reset, run 2 frames.
  - HS high 4 of every 28 cycles; VS high 56 cycles per 392-cycle frame.
  - DE high 16 cycles per line on 8 lines (128 per frame).
  - frame_start period 392.
- Colour bar: pattern_sel=0.
  - Each active line reads FFFFFF×2, FFFF00×2, 00FFFF×2, 00FF00×2, FF00FF×2, FF0000×2, 0000FF×2, 000000×2.
  - pixel_xpos runs 0..15.
- Frame-boundary switching: pattern_sel=0, then 4 with solid_rgb=123456 mid-frame.
  - Current frame stays colour bar.
  - Next frame all 128 DE pixels equal 123456.
- Checkerboard and reserved: pattern_sel=3 with H_DISP=128 → x=63 white only when y[5]=0, x=64 flips. pattern_sel=6 → all 000000.
- Mid-frame reset: assert sys_rst_n=0 at cycle 200 for 3 cycles.
  - Outputs go to reset values asynchronously, with video_hs=video_vs=0.
  - frame_start occurs 2 edges after release.
- MOVING_BOX_EN: after 3 frames box at (6,6) reads FF8000; at H_DISP=64 the box reverses at x=32.
